sound_sequencer: RTL
====================

# sound_sequencer

Arbitrates the single tone-generator channel between the game's audio event sources: frog lost, frog won, and gate taken. It plays a fixed short melody for each event by stepping through notes and gaps with a tick counter. It sits between the game FSM's event outputs and the audio codec's tone generator, and replaces the one-shot `sound_freq`/`enable_sound` pair with a sequenced, prioritised stream.

## Interface

Parameters:
- `NOTE_TICKS`, default 12_500_000: clock cycles each note sounds (0.25 s at 50 MHz). Must be ≥1.
- `GAP_TICKS`, default 2_500_000: silent cycles between consecutive notes of one melody. Must be ≥1.
- `CNT_W`, default 26: tick counter width. Must hold `max(NOTE_TICKS, GAP_TICKS) - 1`.

Ports:
- `clk`: input, 1 bit. System clock, one clock domain.
- `resetN`: input, 1 bit. Asynchronous, active-low reset.
- `lose_req`: input, 1 bit. Single-cycle pulse: play the LOSE melody. Priority 3, the highest.
- `win_req`: input, 1 bit. Single-cycle pulse: play the WIN melody. Priority 2.
- `gate_req`: input, 1 bit. Single-cycle pulse: play the GATE melody. Priority 1.
- `tone_freq`: output, 10 bits. Note frequency in Hz; 0 when silent.
- `enable_sound`: output, 1 bit. High only while a note sounds.
- `busy`: output, 1 bit. High while a melody is in progress, including its gaps.
- `cur_melody`: output, 2 bits. Melody in progress: 0 = none, 1 = GATE, 2 = WIN, 3 = LOSE.
- `done`: output, 1 bit. One-cycle pulse when a melody completes without being preempted.

## Operation

Melody ROM (fixed, in Hz):
- LOSE: 392, 330, 262 (3 notes).
- WIN: 262, 330, 392, 523 (4 notes).
- GATE: 660 (1 note).

FSM states are IDLE, NOTE, GAP. Registers are `state`, `melody[1:0]`, `note_idx[1:0]`, and `cnt[CNT_W-1:0]`.

Request arbitration, evaluated every cycle:
- `req_pri` is the highest-priority request asserted this cycle; 0 if none.
- **Accept condition:** `req_pri > cur_melody`. This covers both IDLE (`cur_melody` = 0) and preemption.
- **On accept:**
  - `melody` ← `req_pri`, `note_idx` ← 0, `cnt` ← `NOTE_TICKS-1`, `state` ← NOTE.
  - No `done` is issued for a preempted melody.
- **Not accepted:** any request with priority ≤ `cur_melody` is dropped. It is never queued.
- **Simultaneous requests:** the highest priority wins; the others are dropped.

State transitions, when no request is accepted:
- **NOTE, `cnt` ≠ 0:** `cnt` decrements.
- **NOTE, `cnt` = 0:**
  - If `note_idx` is the last note of the melody, go to IDLE, set `melody` ← 0, and assert `done` for the next cycle.
  - Otherwise go to GAP and load `cnt` ← `GAP_TICKS-1`.
- **GAP, `cnt` ≠ 0:** `cnt` decrements.
- **GAP, `cnt` = 0:** `note_idx` increments, `cnt` ← `NOTE_TICKS-1`, go to NOTE.

Outputs, all registered or decoded from registered state:
- `tone_freq` = ROM[`melody`][`note_idx`] in NOTE, otherwise 0.
- `enable_sound` = (`state` == NOTE).
- `busy` = (`state` ≠ IDLE).
- `cur_melody` = `melody`.
- `done` is registered.

Reset values (asynchronous, any cycle, including mid-melody):
- `state` = IDLE; `melody`, `note_idx`, `cnt` = 0.
- All outputs 0.
- After reset, no `done` is issued for the aborted melody.

## Timing

- A request sampled at rising edge *t* produces the first note on `tone_freq`/`enable_sound` in cycle *t+1*.
- Each note lasts exactly `NOTE_TICKS` cycles. Each gap lasts exactly `GAP_TICKS` cycles.
- An N-note melody keeps `busy` high for `N·NOTE_TICKS + (N−1)·GAP_TICKS` cycles.
- `done` is high in the first IDLE cycle, coincident with `busy` = 0.
- A request arriving in the same cycle as `done` is accepted normally.
- Preemption takes effect the cycle after the higher-priority request. There are no silent cycles between the old note and the new one.

## Test plan

All scenarios use `NOTE_TICKS`=4 and `GAP_TICKS`=2.

1. **LOSE melody.** `lose_req` pulses in cycle 0.
   - Cycles 1–4: `tone_freq`=392, `enable_sound`=1.
   - Cycles 5–6: `tone_freq`=0, `enable_sound`=0, `busy`=1.
   - Cycles 7–10: `tone_freq`=330.
   - Cycles 13–16: `tone_freq`=262.
   - Cycle 17: `done`=1, `busy`=0.
2. **WIN and GATE timing.** `win_req` in cycle 0 gives notes 262/330/392/523 and `done` in cycle 23. `gate_req` in cycle 0 gives 660 in cycles 1–4 and `done` in cycle 5.
3. **Preemption.**
   - `gate_req` in cycle 0, `win_req` in cycle 2: cycle 3 shows `tone_freq`=262 with `cur_melody`=2, and no `done` in cycle 5.
   - Then `lose_req` in cycle 6: cycle 7 shows `tone_freq`=392 with `cur_melody`=3.
4. **Drop and simultaneity.**
   - `lose_req` in cycle 0, then `gate_req` and `win_req` in cycle 3: both are ignored and the LOSE sequence matches scenario 1 exactly.
   - All three requests in the same cycle: LOSE plays.
5. **Reset mid-melody.** `win_req` in cycle 0, `resetN` low in cycles 9–10:
   - All outputs are 0 immediately, with no `done`.
   - A `gate_req` after reset release plays 660 from the next cycle.

Source files
------------

// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sound_sequencer
// Description : Prioritised melody player driving the single tone channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sound_sequencer #(
  parameter int NOTE_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 2_500_000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       lose_req,
  input  logic       win_req,
  input  logic       gate_req,
  output logic [9:0] tone_freq,
  output logic       enable_sound,
  output logic       busy,
  output logic [1:0] cur_melody,
  output logic       done
);

  localparam logic [CNT_W-1:0] C_NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NOTE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state,    w_state_nxt;
  logic [1:0]       r_melody,   w_melody_nxt;
  logic [1:0]       r_note_idx, w_note_idx_nxt;
  logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
  logic             r_done,     w_done_nxt;
  logic [1:0]       w_req_pri;
  logic [1:0]       w_last_idx;
  logic             w_accept;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_melody   <= 2'd0;
      r_note_idx <= 2'd0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_melody   <= w_melody_nxt;
      r_note_idx <= w_note_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_req_pri      = 2'd0;
    w_last_idx     = 2'd0;
    w_state_nxt    = r_state;
    w_melody_nxt   = r_melody;
    w_note_idx_nxt = r_note_idx;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = 1'b0;

    if (lose_req)      w_req_pri = 2'd3;
    else if (win_req)  w_req_pri = 2'd2;
    else if (gate_req) w_req_pri = 2'd1;

    case (r_melody)
      2'd3:    w_last_idx = 2'd2;
      2'd2:    w_last_idx = 2'd3;
      default: w_last_idx = 2'd0;
    endcase

    // A strictly higher request restarts the channel, which also covers IDLE.
    w_accept = (w_req_pri > r_melody);

    if (w_accept) begin
      w_state_nxt    = S_NOTE;
      w_melody_nxt   = w_req_pri;
      w_note_idx_nxt = 2'd0;
      w_cnt_nxt      = C_NOTE_LOAD;
    end else begin
      case (r_state)
        S_NOTE: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end else if (r_note_idx == w_last_idx) begin
            w_state_nxt    = S_IDLE;
            w_melody_nxt   = 2'd0;
            w_note_idx_nxt = 2'd0;
            w_done_nxt     = 1'b1;
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = C_GAP_LOAD;
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - C_CNT_ONE;
          end else begin
            w_state_nxt    = S_NOTE;
            w_note_idx_nxt = r_note_idx + 2'd1;
            w_cnt_nxt      = C_NOTE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // Melody ROM, indexed by {melody, note_idx}.
  always_comb begin
    tone_freq = 10'd0;
    if (r_state == S_NOTE) begin
      case ({r_melody, r_note_idx})
        4'b11_00: tone_freq = 10'd392;
        4'b11_01: tone_freq = 10'd330;
        4'b11_10: tone_freq = 10'd262;
        4'b10_00: tone_freq = 10'd262;
        4'b10_01: tone_freq = 10'd330;
        4'b10_10: tone_freq = 10'd392;
        4'b10_11: tone_freq = 10'd523;
        4'b01_00: tone_freq = 10'd660;
        default:  tone_freq = 10'd0;
      endcase
    end
  end

  assign enable_sound = (r_state == S_NOTE);
  assign busy         = (r_state != S_IDLE);
  assign cur_melody   = r_melody;
  assign done         = r_done;

endmodule
`default_nettype wire
